stdp_synapse_pair: RTL and testbench

Parametrised pre/post leaky-integrate-and-fire neuron pair joined by one plastic synapse with an on-chip pair-based STDP rule. It is the next generation of the two-neuron top-level demo. The presynaptic spike drives the postsynaptic neuron through a learned weight, and spike timing updates that weight online. It adds a configurable width, threshold, leak, refractory period and STDP window; a global enable; a learn enable; and a synchronous weight load for test.

---
 rtl/stdp_synapse_pair.sv | 187 ++++++++++++++++++
 tb/tb_stdp_synapse_pair.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_synapse_pair.sv
// stdp_synapse_pair: a presynaptic and a postsynaptic leaky-integrate-and-fire
// neuron joined by one plastic synapse. The pre spike injects the current
// weight into the post neuron, and pair-based STDP nudges the weight from the
// relative timing of the two spikes.
module stdp_synapse_pair #(
    parameter int W          = 8,
    parameter int THRESH     = 128,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 2,
    parameter int TBITS      = 4,
    parameter int DW_SHIFT   = 1,
    parameter int W_INIT     = 64,
    parameter int W_MIN      = 0,
    parameter int W_MAX      = (1 << W) - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         learn_en,
    input  logic [W-1:0] pre_current,
    input  logic [W-1:0] post_ext,
    input  logic         w_load,
    input  logic [W-1:0] w_load_val,
    output logic         pre_spike,
    output logic         post_spike,
    output logic [W-1:0] pre_state,
    output logic [W-1:0] post_state,
    output logic [W-1:0] weight,
    output logic         w_update,
    output logic         w_dir
);

    // Refractory counter must hold REFRAC; keep at least one bit when REFRAC is 0.
    localparam int               RBITS    = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [RBITS-1:0] REFRAC_L = RBITS'(REFRAC);
    localparam logic [W:0]       THRESH_L = (W + 1)'(THRESH);
    localparam logic [TBITS-1:0] TMAX     = '1;
    localparam logic [W:0]       W_MAX_L  = (W + 1)'(W_MAX);
    localparam logic [W:0]       W_MIN_L  = (W + 1)'(W_MIN);
    localparam logic [W-1:0]     W_MAX_W  = W'(W_MAX);
    localparam logic [W-1:0]     W_MIN_W  = W'(W_MIN);
    localparam logic [W-1:0]     W_INIT_W = W'(W_INIT);

    logic [RBITS-1:0] pre_refr;
    logic [RBITS-1:0] post_refr;
    logic [TBITS-1:0] pre_timer;
    logic [TBITS-1:0] post_timer;

    logic [W:0]       post_in_raw;
    logic [W-1:0]     post_in;
    logic [W-1:0]     pre_sum;
    logic [W-1:0]     post_sum;
    logic             pre_fire;
    logic             post_fire;

    logic [TBITS-1:0] ltp_dw;
    logic [TBITS-1:0] ltd_dw;
    logic             ltp_hit;
    logic             ltd_hit;
    logic [W:0]       ltp_sum;
    logic [W:0]       ltd_floor;
    logic [W-1:0]     w_up;
    logic [W-1:0]     w_down;

    // Leaky integration: subtract the leak, add the input, saturate at all-ones.
    // The subtraction cannot underflow because the leak is a right shift of state.
    function automatic logic [W-1:0] lif_sum(input logic [W-1:0] s, input logic [W-1:0] i);
        logic [W:0] raw;
        raw = {1'b0, s} - {1'b0, (s >> LEAK_SHIFT)} + {1'b0, i};
        return raw[W] ? {W{1'b1}} : raw[W-1:0];
    endfunction

    // Post neuron sees its external drive plus the weight while pre_spike is high.
    always_comb begin
        post_in_raw = {1'b0, post_ext} + (pre_spike ? {1'b0, weight} : '0);
        post_in     = post_in_raw[W] ? {W{1'b1}} : post_in_raw[W-1:0];
        pre_sum     = lif_sum(pre_state, pre_current);
        post_sum    = lif_sum(post_state, post_in);
        pre_fire    = ({1'b0, pre_sum} >= THRESH_L);
        post_fire   = ({1'b0, post_sum} >= THRESH_L);
    end

    // Pre neuron membrane, spike pulse and refractory countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_state <= '0;
            pre_refr  <= '0;
            pre_spike <= 1'b0;
        end else if (en) begin
            if (pre_refr != '0) begin
                pre_state <= '0;
                pre_refr  <= pre_refr - 1'b1;
                pre_spike <= 1'b0;
            end else if (pre_fire) begin
                pre_state <= '0;
                pre_refr  <= REFRAC_L;
                pre_spike <= 1'b1;
            end else begin
                pre_state <= pre_sum;
                pre_spike <= 1'b0;
            end
        end else begin
            pre_spike <= 1'b0;
        end
    end

    // Post neuron membrane, spike pulse and refractory countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_state <= '0;
            post_refr  <= '0;
            post_spike <= 1'b0;
        end else if (en) begin
            if (post_refr != '0) begin
                post_state <= '0;
                post_refr  <= post_refr - 1'b1;
                post_spike <= 1'b0;
            end else if (post_fire) begin
                post_state <= '0;
                post_refr  <= REFRAC_L;
                post_spike <= 1'b1;
            end else begin
                post_state <= post_sum;
                post_spike <= 1'b0;
            end
        end else begin
            post_spike <= 1'b0;
        end
    end

    // Time-since-spike counters; TMAX doubles as "no recent spike".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_timer  <= TMAX;
            post_timer <= TMAX;
        end else if (en) begin
            if (pre_spike) begin
                pre_timer <= '0;
            end else if (pre_timer != TMAX) begin
                pre_timer <= pre_timer + 1'b1;
            end
            if (post_spike) begin
                post_timer <= '0;
            end else if (post_timer != TMAX) begin
                post_timer <= post_timer + 1'b1;
            end
        end
    end

    // STDP decision: a lone post spike after a recent pre spike potentiates, a
    // lone pre spike after a recent post spike depresses; closer pairs step harder.
    always_comb begin
        ltp_dw    = (TMAX - pre_timer) >> DW_SHIFT;
        ltd_dw    = (TMAX - post_timer) >> DW_SHIFT;
        ltp_hit   = learn_en && post_spike && !pre_spike &&
                    (pre_timer != TMAX) && (ltp_dw != '0);
        ltd_hit   = learn_en && pre_spike && !post_spike &&
                    (post_timer != TMAX) && (ltd_dw != '0);
        ltp_sum   = {1'b0, weight} + (W + 1)'(ltp_dw);
        ltd_floor = W_MIN_L + (W + 1)'(ltd_dw);
        w_up      = (ltp_sum > W_MAX_L) ? W_MAX_W : ltp_sum[W-1:0];
        w_down    = ({1'b0, weight} < ltd_floor) ? W_MIN_W : (weight - W'(ltd_dw));
    end

    // Weight register: test load wins, otherwise apply at most one STDP step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight   <= W_INIT_W;
            w_update <= 1'b0;
            w_dir    <= 1'b0;
        end else if (w_load) begin
            weight   <= w_load_val;
            w_update <= 1'b0;
        end else if (en && ltp_hit) begin
            weight   <= w_up;
            w_update <= 1'b1;
            w_dir    <= 1'b1;
        end else if (en && ltd_hit) begin
            weight   <= w_down;
            w_update <= 1'b1;
            w_dir    <= 1'b0;
        end else begin
            w_update <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stdp_synapse_pair.sv
// tb_stdp_synapse_pair: directed scoreboard bench for the STDP synapse pair.
module tb_stdp_synapse_pair;

    localparam int K_PRE_STATE  = 0;
    localparam int K_POST_STATE = 1;
    localparam int K_WEIGHT     = 2;
    localparam int K_PRE_SPIKE  = 3;
    localparam int K_POST_SPIKE = 4;
    localparam int K_W_UPDATE   = 5;
    localparam int K_W_DIR      = 6;
    localparam int K_PRE_TIMER  = 7;
    localparam int K_POST_TIMER = 8;

    typedef struct {
        string      tag;
        int         kind;
        logic [7:0] exp;
    } sb_entry_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       learn_en;
    logic [7:0] pre_current;
    logic [7:0] post_ext;
    logic       w_load;
    logic [7:0] w_load_val;
    logic       pre_spike;
    logic       post_spike;
    logic [7:0] pre_state;
    logic [7:0] post_state;
    logic [7:0] weight;
    logic       w_update;
    logic       w_dir;

    sb_entry_t  sb[$];
    int         checks   = 0;
    int         failures = 0;

    int lif_pre  [10] = '{64, 120, 0, 0, 0, 64, 120, 0, 0, 0};
    int lif_spk  [10] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0};
    int lif_post [10] = '{0, 0, 0, 64, 56, 49, 43, 38, 98, 86};

    stdp_synapse_pair #(
        .W(8), .THRESH(128), .LEAK_SHIFT(3), .REFRAC(2), .TBITS(4),
        .DW_SHIFT(1), .W_INIT(64), .W_MIN(0), .W_MAX(255)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .learn_en(learn_en),
        .pre_current(pre_current),
        .post_ext(post_ext),
        .w_load(w_load),
        .w_load_val(w_load_val),
        .pre_spike(pre_spike),
        .post_spike(post_spike),
        .pre_state(pre_state),
        .post_state(post_state),
        .weight(weight),
        .w_update(w_update),
        .w_dir(w_dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] observe(input int kind);
        case (kind)
            K_PRE_STATE:  return pre_state;
            K_POST_STATE: return post_state;
            K_WEIGHT:     return weight;
            K_PRE_SPIKE:  return {7'd0, pre_spike};
            K_POST_SPIKE: return {7'd0, post_spike};
            K_W_UPDATE:   return {7'd0, w_update};
            K_W_DIR:      return {7'd0, w_dir};
            K_PRE_TIMER:  return {4'd0, dut.pre_timer};
            K_POST_TIMER: return {4'd0, dut.post_timer};
            default:      return 8'd0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [7:0] pc, input logic [7:0] pe, input logic e,
                                 input logic le, input logic wl, input logic [7:0] wlv);
        pre_current = pc;
        post_ext    = pe;
        en          = e;
        learn_en    = le;
        w_load      = wl;
        w_load_val  = wlv;
    endtask

    task automatic push_expect(input string tag, input int kind, input int val);
        sb_entry_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = 8'(val);
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        sb_entry_t  e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("[TB] FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic push_reset_expect(input string tag);
        push_expect({tag, "_pre_state"},  K_PRE_STATE,  0);
        push_expect({tag, "_post_state"}, K_POST_STATE, 0);
        push_expect({tag, "_weight"},     K_WEIGHT,     64);
        push_expect({tag, "_pre_spike"},  K_PRE_SPIKE,  0);
        push_expect({tag, "_post_spike"}, K_POST_SPIKE, 0);
        push_expect({tag, "_w_update"},   K_W_UPDATE,   0);
        push_expect({tag, "_w_dir"},      K_W_DIR,      0);
        push_expect({tag, "_pre_timer"},  K_PRE_TIMER,  15);
        push_expect({tag, "_post_timer"}, K_POST_TIMER, 15);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        push_reset_expect("reset");
        checkOutput();
        rst_n = 1'b1;

        $display("[TB] LIF cycle");
        applyStimulus(64, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            push_expect($sformatf("lif_pre_state_%0d", i), K_PRE_STATE, lif_pre[i]);
            push_expect($sformatf("lif_pre_spike_%0d", i), K_PRE_SPIKE, lif_spk[i]);
            push_expect($sformatf("lif_post_state_%0d", i), K_POST_STATE, lif_post[i]);
            tick();
        end

        $display("[TB] LTP pair");
        do_reset();
        applyStimulus(0, 0, 1, 1, 1, 64);
        push_expect("ltp_load", K_WEIGHT, 64);
        tick();
        applyStimulus(255, 0, 1, 1, 0, 0);
        push_expect("ltp_pre_spike", K_PRE_SPIKE, 1);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0);
        push_expect("ltp_post_integrates_w", K_POST_STATE, 64);
        push_expect("ltp_pre_timer0", K_PRE_TIMER, 0);
        tick();
        tick();
        tick();
        applyStimulus(0, 255, 1, 1, 0, 0);
        push_expect("ltp_post_spike", K_POST_SPIKE, 1);
        push_expect("ltp_pre_timer", K_PRE_TIMER, 3);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0);
        push_expect("ltp_weight", K_WEIGHT, 70);
        push_expect("ltp_w_update", K_W_UPDATE, 1);
        push_expect("ltp_w_dir", K_W_DIR, 1);
        tick();
        push_expect("ltp_pulse_end", K_W_UPDATE, 0);
        push_expect("ltp_weight_hold", K_WEIGHT, 70);
        tick();

        $display("[TB] LTD pair");
        do_reset();
        applyStimulus(0, 0, 1, 1, 1, 64);
        tick();
        applyStimulus(0, 255, 1, 1, 0, 0);
        push_expect("ltd_post_spike", K_POST_SPIKE, 1);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0);
        push_expect("ltd_post_timer0", K_POST_TIMER, 0);
        tick();
        tick();
        tick();
        applyStimulus(255, 0, 1, 1, 0, 0);
        push_expect("ltd_pre_spike", K_PRE_SPIKE, 1);
        push_expect("ltd_post_timer", K_POST_TIMER, 3);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0);
        push_expect("ltd_weight", K_WEIGHT, 58);
        push_expect("ltd_w_update", K_W_UPDATE, 1);
        push_expect("ltd_w_dir", K_W_DIR, 0);
        tick();

        $display("[TB] LTP clamp");
        do_reset();
        applyStimulus(0, 0, 1, 1, 1, 253);
        tick();
        applyStimulus(255, 0, 1, 1, 0, 0);
        push_expect("clamp_hi_pre_spike", K_PRE_SPIKE, 1);
        tick();
        applyStimulus(0, 255, 1, 1, 0, 0);
        push_expect("clamp_hi_post_spike", K_POST_SPIKE, 1);
        push_expect("clamp_hi_pre_timer", K_PRE_TIMER, 0);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0);
        push_expect("clamp_hi_weight", K_WEIGHT, 255);
        push_expect("clamp_hi_w_update", K_W_UPDATE, 1);
        push_expect("clamp_hi_w_dir", K_W_DIR, 1);
        tick();

        $display("[TB] LTD clamp");
        do_reset();
        applyStimulus(0, 0, 1, 1, 1, 3);
        tick();
        applyStimulus(0, 255, 1, 1, 0, 0);
        push_expect("clamp_lo_post_spike", K_POST_SPIKE, 1);
        tick();
        applyStimulus(255, 0, 1, 1, 0, 0);
        push_expect("clamp_lo_pre_spike", K_PRE_SPIKE, 1);
        push_expect("clamp_lo_post_timer", K_POST_TIMER, 0);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0);
        push_expect("clamp_lo_weight", K_WEIGHT, 0);
        push_expect("clamp_lo_w_update", K_W_UPDATE, 1);
        push_expect("clamp_lo_w_dir", K_W_DIR, 0);
        tick();

        $display("[TB] window edge");
        do_reset();
        applyStimulus(0, 0, 1, 1, 1, 64);
        tick();
        applyStimulus(255, 0, 1, 1, 0, 0);
        push_expect("win_pre_spike", K_PRE_SPIKE, 1);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0);
        repeat (15) tick();
        applyStimulus(0, 255, 1, 1, 0, 0);
        push_expect("win_post_spike", K_POST_SPIKE, 1);
        push_expect("win_pre_timer_sat", K_PRE_TIMER, 15);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0);
        push_expect("win_no_update", K_W_UPDATE, 0);
        push_expect("win_weight", K_WEIGHT, 64);
        tick();

        $display("[TB] simultaneous spikes");
        do_reset();
        applyStimulus(255, 255, 1, 1, 0, 0);
        push_expect("sim_pre_spike", K_PRE_SPIKE, 1);
        push_expect("sim_post_spike", K_POST_SPIKE, 1);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 0);
        push_expect("sim_pre_timer", K_PRE_TIMER, 0);
        push_expect("sim_post_timer", K_POST_TIMER, 0);
        push_expect("sim_weight", K_WEIGHT, 64);
        push_expect("sim_w_update", K_W_UPDATE, 0);
        tick();

        $display("[TB] learning disabled");
        do_reset();
        applyStimulus(255, 0, 1, 0, 0, 0);
        push_expect("nolearn_pre_spike", K_PRE_SPIKE, 1);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 0);
        repeat (3) tick();
        applyStimulus(0, 255, 1, 0, 0, 0);
        push_expect("nolearn_post_spike", K_POST_SPIKE, 1);
        push_expect("nolearn_pre_timer", K_PRE_TIMER, 3);
        tick();
        applyStimulus(0, 0, 1, 0, 0, 0);
        push_expect("nolearn_weight", K_WEIGHT, 64);
        push_expect("nolearn_w_update", K_W_UPDATE, 0);
        tick();

        $display("[TB] enable gating");
        do_reset();
        applyStimulus(64, 0, 1, 1, 0, 0);
        push_expect("en_pre_state_a", K_PRE_STATE, 64);
        tick();
        push_expect("en_pre_state_b", K_PRE_STATE, 120);
        tick();
        applyStimulus(255, 255, 0, 1, 0, 0);
        push_expect("frz_pre_state", K_PRE_STATE, 120);
        push_expect("frz_post_state", K_POST_STATE, 0);
        push_expect("frz_pre_spike", K_PRE_SPIKE, 0);
        push_expect("frz_pre_timer", K_PRE_TIMER, 15);
        tick();
        push_expect("frz_pre_state2", K_PRE_STATE, 120);
        push_expect("frz_post_spike", K_POST_SPIKE, 0);
        tick();
        applyStimulus(255, 255, 0, 1, 1, 99);
        push_expect("frz_load_weight", K_WEIGHT, 99);
        push_expect("frz_load_pre_state", K_PRE_STATE, 120);
        tick();
        applyStimulus(64, 0, 1, 1, 0, 0);
        push_expect("en_resume_spike", K_PRE_SPIKE, 1);
        push_expect("en_resume_state", K_PRE_STATE, 0);
        tick();
        applyStimulus(64, 0, 0, 1, 0, 0);
        push_expect("en_off_clears_spike", K_PRE_SPIKE, 0);
        push_expect("en_off_state", K_PRE_STATE, 0);
        tick();
        applyStimulus(64, 0, 1, 1, 0, 0);
        push_expect("refr_hold_1", K_PRE_STATE, 0);
        tick();
        push_expect("refr_hold_2", K_PRE_STATE, 0);
        tick();
        push_expect("refr_done", K_PRE_STATE, 64);
        push_expect("frz_weight_kept", K_WEIGHT, 99);
        tick();

        $display("[TB] mid-run reset");
        do_reset();
        applyStimulus(64, 0, 1, 1, 1, 200);
        push_expect("mid_pre_state_a", K_PRE_STATE, 64);
        push_expect("mid_weight_load", K_WEIGHT, 200);
        tick();
        applyStimulus(64, 0, 1, 1, 0, 0);
        push_expect("mid_pre_state_b", K_PRE_STATE, 120);
        tick();
        rst_n = 1'b0;
        #2;
        push_reset_expect("midrst");
        checkOutput();
        rst_n = 1'b1;
        push_expect("midrst_first_integration", K_PRE_STATE, 64);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
